adc_conv_sequencer: RTL and testbench
=====================================

// Module: adc_conv_sequencer
// PURPOSE
//  Autonomous conversion scheduler for the 8-bit parallel ADC on the 1.8 V bank. Holds PD low
//  through power-up, issues periodic CONVST pulses, waits for EOC, drives RD, captures DB[7:0]
//  and offers each sample on a valid/ready interface to downstream logic.
//  Sits between the ADC pins and the sample-consuming datapath.
//  Replaces manual CONVST/PD driving from upstream logic.
// PARAMETERS
//  PWRUP_CYCLES    2000  cycles PD_18 held low after reset before first conversion (20 us)
//  SAMPLE_PERIOD   100   cycles between conversion start ticks (1 MS/s); legal >= 32
//  CONVST_LOW      4     cycles CONVST_18 held low per conversion
//  EOC_TIMEOUT     64    max cycles to wait for synchronised EOC low before aborting
//  RD_SETUP        2     cycles after RD_18 falls before DB is captured (20 ns)
//  RD_LOW          6     total cycles RD_18 held low; legal RD_LOW > RD_SETUP
// PORTS
//  clk_100M      in   1  100 MHz system clock
//  Reset         in   1  asynchronous, active-low reset
//  enable        in   1  1 = run periodic conversions; sampled at each start tick
//  EOC_18        in   1  ADC end-of-conversion, active low, asynchronous to clk_100M
//  DB_in         in   8  ADC parallel data bus
//  CONVST_18     out  1  ADC convert start, active low
//  RD_18         out  1  ADC read strobe, active low
//  PD_18         out  1  ADC power-down control, 0 = powered down
//  sample_data   out  8  captured sample
//  sample_valid  out  1  sample_data holds an unconsumed sample
//  sample_ready  in   1  downstream accepts sample when valid && ready
//  overrun       out  1  1-cycle pulse: new sample overwrote an unconsumed one
//  timeout       out  1  1-cycle pulse: EOC not seen within EOC_TIMEOUT
//  busy          out  1  1 while state is not IDLE/PWRUP
// BEHAVIOUR
//  Reset (async, Reset=0): state=PWRUP, CONVST_18=1, RD_18=1, PD_18=0, sample_data=0,
//   sample_valid=0, overrun=0, timeout=0, busy=0, all counters 0. All outputs registered.
//  EOC_18 passes a 2-flop synchroniser (eoc_s); all EOC decisions use eoc_s (+2 cycles).
//  Period counter: runs from leaving PWRUP; counts 0..SAMPLE_PERIOD-1 and wraps; tick = (cnt==0).
//  FSM:
//   PWRUP    PD_18=0; after PWRUP_CYCLES cycles -> IDLE, PD_18=1 thereafter until reset.
//   IDLE     on tick && enable -> CONVST. tick while busy or !enable is discarded (no queue).
//   CONVST   CONVST_18=0 for CONVST_LOW cycles -> WAIT_EOC (CONVST_18 back to 1).
//   WAIT_EOC eoc_s==0 -> RD_SET; else after EOC_TIMEOUT cycles: timeout pulse, -> IDLE.
//   RD_SET   RD_18=0; on RD low cycle index RD_SETUP (first low cycle = 0) register DB_in
//            -> RD_HOLD.
//   RD_HOLD  RD_18 stays 0 until RD_LOW cycles total, then RD_18=1 -> IDLE.
//  Capture rule: sample_data<=DB_in, sample_valid<=1 on capture cycle. If sample_valid=1 and
//   not consumed in that same cycle, data is overwritten and overrun pulses 1 cycle.
//  Handshake: valid && ready clears sample_valid next cycle; capture in same cycle wins
//   (valid stays 1, new data, no overrun). sample_data stable while valid && !ready.
//  enable deasserted mid-conversion: current conversion completes and is delivered; no new start.
//  Reset mid-operation: immediate return to reset values, including PD_18=0 and re-running PWRUP.
//  Latency: start tick -> CONVST_18 fall 1 cycle; EOC_18 fall -> RD_18 fall 3 cycles;
//   RD_18 fall -> sample_valid 1 at RD_SETUP+1 cycles.
// TESTING
//  Reset: hold Reset=0 -> CONVST_18=1, RD_18=1, PD_18=0, sample_valid=0; release -> PD_18 rises
//   exactly 2000 cycles later.
//  Single conversion: enable=1, ADC model drops EOC_18 600 ns after CONVST_18 fall, DB=8'hA5 ->
//   CONVST low 4 cycles, RD low 6 cycles, sample_data=8'hA5, sample_valid=1; starts 100 cycles apart.
//  Backpressure: sample_ready=0, two conversions DB=8'h11 then 8'h22 -> overrun pulses once,
//   sample_data=8'h22; ready=1 then clears valid next cycle.
//  Timeout: EOC_18 held 1 -> timeout pulse 64 cycles after WAIT_EOC entry, RD_18 never falls,
//   next tick starts a new conversion.
//  Enable drop: deassert enable during WAIT_EOC -> sample still delivered, no further CONVST fall.
//  Mid-op reset: assert Reset during RD_HOLD -> RD_18=1, PD_18=0 asynchronously, valid=0.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// ---------------------------------------------------------------------------
// adc_conv_sequencer
//
// Autonomous conversion scheduler for the 8-bit parallel ADC on the 1.8 V
// bank. It keeps the ADC powered down through power-up, then issues periodic
// CONVST pulses. For each pulse it waits for EOC, strobes RD and captures DB.
// Each captured sample is offered to downstream logic on a valid/ready
// interface.
//
// Ports
//   clk_100M      in   100 MHz system clock
//   Reset         in   asynchronous, active-low reset
//   enable        in   1 = run periodic conversions (sampled at each start tick)
//   EOC_18        in   ADC end-of-conversion, active low, asynchronous
//   DB_in         in   ADC parallel data bus
//   CONVST_18     out  ADC convert start, active low
//   RD_18         out  ADC read strobe, active low
//   PD_18         out  ADC power-down control, 0 = powered down
//   sample_data   out  captured sample
//   sample_valid  out  sample_data holds an unconsumed sample
//   sample_ready  in   downstream accepts the sample when valid && ready
//   overrun       out  1-cycle pulse: new sample overwrote an unconsumed one
//   timeout       out  1-cycle pulse: EOC not seen within EOC_TIMEOUT cycles
//   busy          out  1 while a conversion is in progress
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_conv_sequencer #(
  parameter int PWRUP_CYCLES  = 2000,
  parameter int SAMPLE_PERIOD = 100,
  parameter int CONVST_LOW    = 4,
  parameter int EOC_TIMEOUT   = 64,
  parameter int RD_SETUP      = 2,
  parameter int RD_LOW        = 6,
  parameter int DATA_W        = 8
) (
  input  logic              clk_100M,
  input  logic              Reset,
  input  logic              enable,
  input  logic              EOC_18,
  input  logic [DATA_W-1:0] DB_in,
  output logic              CONVST_18,
  output logic              RD_18,
  output logic              PD_18,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              timeout,
  output logic              busy
);

  localparam int MAX_A   = (PWRUP_CYCLES > EOC_TIMEOUT) ? PWRUP_CYCLES : EOC_TIMEOUT;
  localparam int MAX_B   = (CONVST_LOW > RD_LOW) ? CONVST_LOW : RD_LOW;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PER_W   = $clog2(SAMPLE_PERIOD);

  localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(CONVST_LOW - 1);
  localparam logic [CNT_W-1:0] EOC_LAST    = CNT_W'(EOC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RD_CAPT     = CNT_W'(RD_SETUP);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_LOW - 1);
  localparam logic [PER_W-1:0] PER_LAST    = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_CONVST,
    S_WAIT_EOC,
    S_RD_SET,
    S_RD_HOLD
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] st_cnt, cnt_nxt;
  logic [PER_W-1:0] per_cnt;
  logic             eoc_p0, eoc_p1;
  logic             tick;
  logic             convst_nxt, rd_nxt, pd_nxt, timeout_nxt, capture;

  // Start ticks only exist once power-up is over; the counter sits at 0
  // during PWRUP so the first IDLE cycle is a tick.
  assign tick = (state != S_PWRUP) && (per_cnt == '0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = st_cnt + 1'b1;
    convst_nxt  = CONVST_18;
    rd_nxt      = RD_18;
    pd_nxt      = PD_18;
    timeout_nxt = 1'b0;
    capture     = 1'b0;
    case (state)
      S_PWRUP: begin
        pd_nxt = 1'b0;
        if (st_cnt == PWRUP_LAST) begin
          state_nxt = S_IDLE;
          pd_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        cnt_nxt = '0;
        if (tick && enable) begin
          state_nxt  = S_CONVST;
          convst_nxt = 1'b0;
        end
      end
      S_CONVST: begin
        if (st_cnt == CONVST_LAST) begin
          state_nxt  = S_WAIT_EOC;
          convst_nxt = 1'b1;
          cnt_nxt    = '0;
        end
      end
      S_WAIT_EOC: begin
        // A seen EOC wins over a timeout landing on the same cycle.
        if (!eoc_p1) begin
          state_nxt = S_RD_SET;
          rd_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (st_cnt == EOC_LAST) begin
          state_nxt   = S_IDLE;
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
        end
      end
      S_RD_SET: begin
        // st_cnt keeps running into RD_HOLD so it indexes RD-low cycles.
        if (st_cnt == RD_CAPT) begin
          capture = 1'b1;
          if (st_cnt == RD_LAST) begin
            state_nxt = S_IDLE;
            rd_nxt    = 1'b1;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_RD_HOLD;
          end
        end
      end
      S_RD_HOLD: begin
        if (st_cnt == RD_LAST) begin
          state_nxt = S_IDLE;
          rd_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_PWRUP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // EOC synchroniser and FSM state
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      eoc_p0  <= 1'b1;
      eoc_p1  <= 1'b1;
      state   <= S_PWRUP;
      st_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      eoc_p0 <= EOC_18;
      eoc_p1 <= eoc_p0;
      state  <= state_nxt;
      st_cnt <= cnt_nxt;
      if (state == S_PWRUP) begin
        per_cnt <= '0;
      end else if (per_cnt == PER_LAST) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_cnt + 1'b1;
      end
    end
  end

  // Registered pin and sample outputs
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      CONVST_18    <= 1'b1;
      RD_18        <= 1'b1;
      PD_18        <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      CONVST_18 <= convst_nxt;
      RD_18     <= rd_nxt;
      PD_18     <= pd_nxt;
      timeout   <= timeout_nxt;
      busy      <= !(state_nxt inside {S_IDLE, S_PWRUP});
      if (capture) begin
        // A capture on the handshake cycle replaces the consumed sample,
        // so only an unconsumed one counts as overrun.
        sample_data  <= DB_in;
        sample_valid <= 1'b1;
        overrun      <= sample_valid && !sample_ready;
      end else begin
        overrun <= 1'b0;
        if (sample_valid && sample_ready) begin
          sample_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
`timescale 1ns/1ps
module tb_adc_conv_sequencer;

  localparam int PWRUP  = 2000;
  localparam int PERIOD = 100;
  localparam int CLOW   = 4;
  localparam int TMO    = 64;
  localparam int RSET   = 2;
  localparam int RLOW   = 6;

  logic       clk_100M = 1'b0;
  logic       Reset = 1'b1;
  logic       enable = 1'b0;
  logic       EOC_18 = 1'b1;
  logic [7:0] DB_in = 8'h00;
  logic       sample_ready = 1'b0;
  logic       CONVST_18, RD_18, PD_18, sample_valid, overrun, timeout, busy;
  logic [7:0] sample_data;

  adc_conv_sequencer dut (
    .clk_100M     (clk_100M),
    .Reset        (Reset),
    .enable       (enable),
    .EOC_18       (EOC_18),
    .DB_in        (DB_in),
    .CONVST_18    (CONVST_18),
    .RD_18        (RD_18),
    .PD_18        (PD_18),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk_100M = ~clk_100M;

  int checks = 0;
  int passed = 0;

  // Stimulus control
  bit       rnd_on = 1'b0;
  bit       enable_cmd = 1'b0;
  bit       ready_cmd = 1'b0;
  int       adc_mode = 0;        // 0 = never answers, 1 = fixed, 2 = random
  logic [7:0] fixed_db = 8'h00;
  bit       mon_on = 1'b0;
  bit       rd_cut = 1'b0;

  // Reference model state
  logic [7:0] exp_q[$];
  int exp_tmo = 0;
  int eoc_cyc = 0;

  // Observations
  int cyc = 0;
  int conv_falls = 0, conv_rises = 0, rd_falls = 0, tmo_cnt = 0, hs_cnt = 0, ov_cnt = 0;
  int last_fall = 0, prev_fall = 0, conv_rise_cyc = 0, rd_fall_cyc = 0;
  int vld_rise_cyc = 0, tmo_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic check_fail(input string name);
    checks++;
    $display("FAIL %s: event not seen within its cycle budget", name);
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0:       return conv_falls;
      1:       return conv_rises;
      2:       return rd_falls;
      3:       return tmo_cnt;
      default: return hs_cnt;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int target, input int budget, input string name);
    int n = 0;
    while (get_cnt(which) < target && n < budget) begin
      @(negedge clk_100M); #1;
      n++;
    end
    if (get_cnt(which) < target) check_fail(name);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_100M);
    #1;
  endtask

  task automatic release_and_check_pwrup();
    int n = 0;
    @(posedge clk_100M); #1;
    Reset = 1'b1;
    while (!PD_18 && n < PWRUP + 100) begin
      @(posedge clk_100M); #1;
      n++;
    end
    check("pwrup_cycles", n, PWRUP);
  endtask

  initial forever begin
    @(posedge clk_100M);
    cyc++;
  end

  // Input driver: enable/ready change only just after a rising edge
  initial forever begin
    @(posedge clk_100M); #1;
    if (rnd_on) begin
      enable       = ($urandom_range(0, 99) < 80);
      sample_ready = ($urandom_range(0, 1) == 1);
    end else begin
      enable       = enable_cmd;
      sample_ready = ready_cmd;
    end
  end

  // ADC behavioural model; each answered conversion predicts one delivered sample
  initial forever begin
    bit respond;
    int dly;
    logic [7:0] db;
    @(negedge CONVST_18);
    if (mon_on && Reset) begin
      respond = (adc_mode == 1) || (adc_mode == 2 && $urandom_range(0, 3) != 0);
      if (!respond) begin
        exp_tmo++;
      end else begin
        dly = (adc_mode == 1) ? 60 : $urandom_range(10, 50);
        db  = (adc_mode == 1) ? fixed_db : 8'($urandom);
        #(dly * 10 + 3);
        DB_in   = db;
        EOC_18  = 1'b0;
        eoc_cyc = cyc;
        exp_q.push_back(db);
        @(posedge RD_18);
        EOC_18 = 1'b1;
      end
    end
  end

  // Pin monitor and scoreboard
  initial begin
    logic conv_prev = 1'b1, rd_prev = 1'b1, vld_prev = 1'b0, rdy_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    int conv_low = 0, rd_low = 0;
    logic [7:0] e;
    forever begin
      @(negedge clk_100M);
      if (mon_on) begin
        if (conv_prev && !CONVST_18) begin
          conv_falls++;
          prev_fall = last_fall;
          last_fall = cyc;
        end
        if (!conv_prev && CONVST_18) begin
          conv_rises++;
          conv_rise_cyc = cyc;
        end
        if (!CONVST_18) conv_low++;
        else if (conv_low > 0) begin
          check("convst_low_width", conv_low, CLOW);
          conv_low = 0;
        end
        if (rd_prev && !RD_18) begin
          rd_falls++;
          rd_fall_cyc = cyc;
        end
        if (!RD_18) rd_low++;
        else if (rd_low > 0) begin
          if (!rd_cut) check("rd_low_width", rd_low, RLOW);
          rd_cut = 1'b0;
          rd_low = 0;
        end
        if (!vld_prev && sample_valid) vld_rise_cyc = cyc;
        if (overrun) ov_cnt++;
        if (timeout) begin
          tmo_cnt++;
          tmo_cyc = cyc;
        end
        if (vld_prev && !rdy_prev && sample_valid && !overrun)
          check("hold_data", int'(sample_data), int'(data_prev));
        if (sample_valid && sample_ready) begin
          if (exp_q.size() == 0) begin
            check_fail("unexpected_sample");
          end else begin
            e = exp_q.pop_front();
            check("sample_data", int'(sample_data), int'(e));
            hs_cnt++;
          end
        end
      end
      conv_prev = CONVST_18;
      rd_prev   = RD_18;
      vld_prev  = sample_valid;
      rdy_prev  = sample_ready;
      data_prev = sample_data;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, r, h, t, o, et;

    // Reset values
    #1 Reset = 1'b0;
    #20;
    check("rst_convst", int'(CONVST_18), 1);
    check("rst_rd", int'(RD_18), 1);
    check("rst_pd", int'(PD_18), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_data", int'(sample_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_overrun", int'(overrun), 0);
    mon_on = 1'b1;
    release_and_check_pwrup();
    idle_cycles(5);

    // Single conversion
    adc_mode = 1; fixed_db = 8'hA5; ready_cmd = 1'b1; enable_cmd = 1'b1;
    b = conv_falls; h = hs_cnt;
    wait_ev(0, b + 1, 300, "first_convst");
    wait_ev(4, h + 1, 200, "first_sample");
    check("eoc_to_rd_latency", rd_fall_cyc - eoc_cyc, 3);
    check("rd_to_valid_latency", vld_rise_cyc - rd_fall_cyc, RSET + 1);
    wait_ev(0, b + 2, 150, "second_convst");
    check("start_period", last_fall - prev_fall, PERIOD);
    enable_cmd = 1'b0;
    wait_ev(4, h + 2, 200, "second_sample");
    idle_cycles(150);

    // Backpressure and overrun
    adc_mode = 1; fixed_db = 8'h11; ready_cmd = 1'b0; enable_cmd = 1'b1;
    b = conv_falls; r = rd_falls; o = ov_cnt;
    wait_ev(2, r + 1, 300, "bp_rd1");
    fixed_db = 8'h22;
    wait_ev(0, b + 2, 150, "bp_conv2");
    enable_cmd = 1'b0;
    wait_ev(2, r + 2, 150, "bp_rd2");
    idle_cycles(10);
    check("bp_overrun_pulses", ov_cnt - o, 1);
    check("bp_data", int'(sample_data), 8'h22);
    check("bp_valid", int'(sample_valid), 1);
    // The unconsumed 0x11 is lost when 0x22 lands on top of it.
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk_100M);
    ready_cmd = 1'b1;
    @(posedge clk_100M);
    @(negedge clk_100M);
    @(negedge clk_100M); #1;
    check("bp_valid_cleared", int'(sample_valid), 0);
    idle_cycles(150);

    // EOC timeout
    adc_mode = 0; ready_cmd = 1'b1; enable_cmd = 1'b1;
    b = conv_falls; r = rd_falls; t = tmo_cnt;
    wait_ev(3, t + 1, 300, "tmo_first");
    check("tmo_delay", tmo_cyc - conv_rise_cyc, TMO);
    wait_ev(0, b + 2, 100, "tmo_next_start");
    enable_cmd = 1'b0;
    check("tmo_restart_period", last_fall - prev_fall, PERIOD);
    wait_ev(3, t + 2, 150, "tmo_second");
    check("tmo_no_rd", rd_falls, r);
    idle_cycles(150);

    // Enable dropped during WAIT_EOC
    adc_mode = 1; fixed_db = 8'h5A; ready_cmd = 1'b1; enable_cmd = 1'b1;
    b = conv_falls; h = hs_cnt; r = conv_rises;
    wait_ev(1, r + 1, 300, "ed_wait_eoc");
    enable_cmd = 1'b0;
    wait_ev(4, h + 1, 200, "ed_sample");
    idle_cycles(300);
    check("ed_no_restart", conv_falls, b + 1);

    // Randomised run
    adc_mode = 2; b = conv_falls; o = ov_cnt; t = tmo_cnt; et = exp_tmo;
    rnd_on = 1'b1;
    wait_ev(0, b + 30, 6000, "rand_progress");
    rnd_on = 1'b0; enable_cmd = 1'b0; ready_cmd = 1'b1;
    idle_cycles(250);
    check("rand_timeouts", tmo_cnt - t, exp_tmo - et);
    check("rand_overrun", ov_cnt - o, 0);
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset during RD_HOLD
    adc_mode = 1; fixed_db = 8'h3C; ready_cmd = 1'b0; enable_cmd = 1'b1;
    r = rd_falls;
    wait_ev(2, r + 1, 300, "mr_rd_fall");
    repeat (4) @(posedge clk_100M);
    #1;
    check("mr_captured", int'(sample_valid), 1);
    #1;
    rd_cut = 1'b1;
    Reset = 1'b0;
    #1;
    check("mr_rd", int'(RD_18), 1);
    check("mr_pd", int'(PD_18), 0);
    check("mr_valid", int'(sample_valid), 0);
    check("mr_convst", int'(CONVST_18), 1);
    check("mr_busy", int'(busy), 0);
    exp_q.delete();
    enable_cmd = 1'b0;
    idle_cycles(5);
    release_and_check_pwrup();
    idle_cycles(20);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
